// File: rtl/ram_sp_arb_pkg.sv
// Shared types and the round-robin search helper for the ram_sp_arb arbiter.
// Latency: n/a (types and a purely combinational function).
// Backpressure: n/a.
package ram_sp_arb_pkg;

    // Widest requester set supported; narrower sets pass N_REQ to rr_pick.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo n_req.
    // valid is zero-extended to MAX_REQ by the caller; only the low n_req
    // bits take part in the search.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        n_req);
        rr_pick_t         res;
        logic [IDX_W-1:0] cand;
        int unsigned      pos;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            pos  = (32'(ptr) + i) % n_req;
            cand = IDX_W'(pos);
            if (i < n_req && !res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM with per-byte write enables and optional output register.
// Latency: OUT_REG=1 -> data one cycle after rd_en_i; OUT_REG=0 -> combinational.
// Backpressure: none, accepts one access every cycle.
module ram_sp #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int OUT_REG = 1,
    parameter int INIT    = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic                     wr_en_i,
    input  logic                     rd_en_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [WIDTH/8-1:0]       be_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Byte-masked write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (be_i[b]) begin
                    r_mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Output register: only loads on a read so the last read data is held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= WIDTH'(INIT);
        end else if (rd_en_i && OUT_REG != 0) begin
            r_rdata <= r_mem[addr_i];
        end
    end

    assign rdata_o = (OUT_REG != 0) ? r_rdata : r_mem[addr_i];

endmodule

// File: rtl/ram_sp_arb.sv
// Round-robin arbiter sharing one ram_sp among N_REQ requesters, with post-reset zero-fill.
// Latency: read accepted in cycle t returns rsp_valid_o/rsp_data_o in t+1; writes posted.
// Backpressure: req_ready_o is a same-cycle one-hot grant; all low during reset and the clear sweep.
module ram_sp_arb
    import ram_sp_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int OUT_REG = 1,
    parameter int CLEAR   = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [N_REQ-1:0]                 req_wr_i,
    input  logic [N_REQ*$clog2(DEPTH)-1:0]   req_addr_i,
    input  logic [N_REQ*WIDTH-1:0]           req_data_i,
    input  logic [N_REQ*WIDTH/8-1:0]         req_be_i,
    output logic [N_REQ-1:0]                 rsp_valid_o,
    output logic [WIDTH-1:0]                 rsp_data_o,
    output logic                             init_done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = WIDTH / 8;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic [AW-1:0]    r_clr_addr;
    logic             r_pend_vld;
    logic [IDX_W-1:0] r_pend_idx;
    logic [WIDTH-1:0] r_rd_q;

    rr_pick_t         w_pick;
    logic             w_sel_wr;
    logic [AW-1:0]    w_sel_addr;
    logic [WIDTH-1:0] w_sel_data;
    logic [BW-1:0]    w_sel_be;

    logic [AW-1:0]    w_ram_addr;
    logic [WIDTH-1:0] w_ram_wdata;
    logic [BW-1:0]    w_ram_be;
    logic             w_ram_wr;
    logic             w_ram_rd;
    logic [WIDTH-1:0] w_ram_rdata;

    // Round-robin search and mux of the candidate requester's fields.
    always_comb begin
        w_pick     = rr_pick(MAX_REQ'(req_valid_i), r_rr_ptr, N_REQ);
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_be   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pick.idx == IDX_W'(k)) begin
                w_sel_wr   = req_wr_i[k];
                w_sel_addr = req_addr_i[k*AW +: AW];
                w_sel_data = req_data_i[k*WIDTH +: WIDTH];
                w_sel_be   = req_be_i[k*BW +: BW];
            end
        end
    end

    // Next state, grant and RAM port drive; everything is held off while reset is asserted.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        req_ready_o  = '0;
        w_ram_addr   = w_sel_addr;
        w_ram_wdata  = w_sel_data;
        w_ram_be     = w_sel_be;
        w_ram_wr     = 1'b0;
        w_ram_rd     = 1'b0;
        if (!rst_i) begin
            case (r_state)
                CLR: begin
                    w_ram_addr  = r_clr_addr;
                    w_ram_wdata = '0;
                    w_ram_be    = '1;
                    w_ram_wr    = 1'b1;
                    if (r_clr_addr == AW'(DEPTH - 1)) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (w_pick.found) begin
                        for (int k = 0; k < N_REQ; k++) begin
                            req_ready_o[k] = (w_pick.idx == IDX_W'(k));
                        end
                        w_ram_wr     = w_sel_wr;
                        w_ram_rd     = ~w_sel_wr;
                        w_rr_ptr_nxt = (w_pick.idx == IDX_W'(N_REQ - 1)) ? '0
                                                                         : w_pick.idx + IDX_W'(1);
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // State, round-robin pointer and clear-sweep address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= (CLEAR != 0) ? CLR : RUN;
            r_rr_ptr   <= '0;
            r_clr_addr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            if (r_state == CLR) begin
                r_clr_addr <= r_clr_addr + AW'(1);
            end
        end
    end

    // One-deep response tracker; also captures combinational read data when OUT_REG=0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_vld <= 1'b0;
            r_pend_idx <= '0;
            r_rd_q     <= '0;
        end else begin
            r_pend_vld <= w_ram_rd;
            if (w_ram_rd) begin
                r_pend_idx <= w_pick.idx;
                r_rd_q     <= w_ram_rdata;
            end
        end
    end

    // Response strobe decode; a pending response is dropped if reset lands on it.
    always_comb begin
        rsp_valid_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rsp_valid_o[k] = r_pend_vld && !rst_i && (r_pend_idx == IDX_W'(k));
        end
    end

    assign rsp_data_o  = (OUT_REG != 0) ? w_ram_rdata : r_rd_q;
    assign init_done_o = (r_state == RUN);

    ram_sp #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .OUT_REG (OUT_REG),
        .INIT    (0)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (w_ram_addr),
        .wr_en_i (w_ram_wr),
        .rd_en_i (w_ram_rd),
        .wdata_i (w_ram_wdata),
        .be_i    (w_ram_be),
        .rdata_o (w_ram_rdata)
    );

endmodule

// File: tb/tb_ram_sp_arb.sv
// Bench for ram_sp_arb: two instances (OUT_REG=1/CLEAR=1 and OUT_REG=0/CLEAR=0) on shared stimulus.
// Latency: checks are made each negedge against a per-instance reference model.
// Backpressure: requesters hold their fields until the CLEAR=1 instance grants them.
module tb_ram_sp_arb;

    localparam int N = 3;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  v, wr;
    logic [11:0] addr;
    logic [95:0] wdat;
    logic [11:0] be;
    logic [2:0]  rdy0, rdy1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        id0, id1;

    always #5 clk = ~clk;

    ram_sp_arb #(.N_REQ(3), .WIDTH(32), .DEPTH(16), .OUT_REG(1), .CLEAR(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_ready_o(rdy0), .req_wr_i(wr),
        .req_addr_i(addr), .req_data_i(wdat), .req_be_i(be),
        .rsp_valid_o(rv0), .rsp_data_o(rd0), .init_done_o(id0));

    ram_sp_arb #(.N_REQ(3), .WIDTH(32), .DEPTH(16), .OUT_REG(0), .CLEAR(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_ready_o(rdy1), .req_wr_i(wr),
        .req_addr_i(addr), .req_data_i(wdat), .req_be_i(be),
        .rsp_valid_o(rv1), .rsp_data_o(rd1), .init_done_o(id1));

    // Reference model state, one slot per instance.
    int          m_ptr [2];
    bit          m_pv  [2];
    int          m_pi  [2];
    int          m_cyc [2];
    bit          m_init[2];
    logic [31:0] m_data[2];
    bit          m_dk  [2];
    logic [31:0] m_mem [2][D];
    bit   [3:0]  m_kn  [2][D];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  v;
        logic [2:0]  wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [2:0]  e_rdy;
        logic [2:0]  e_rv;
        logic [31:0] e_dat;
        bit          c_dat;
    } vec_t;

    vec_t       tv [18];
    bit         tv_on  = 1'b0;
    int         tv_idx = 0;
    logic [2:0] last_rdy = 3'b000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Checker: compares both instances against the model, then advances the model.
    logic [2:0]  a_rdy, a_rv, e_rdy;
    logic [31:0] a_dat;
    logic        a_id;
    bit          found;
    int          g, j, ad;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            a_rdy = (d == 0) ? rdy0 : rdy1;
            a_rv  = (d == 0) ? rv0  : rv1;
            a_dat = (d == 0) ? rd0  : rd1;
            a_id  = (d == 0) ? id0  : id1;
            if (rst) begin
                chk($sformatf("d%0d_rst_ready", d), 32'(a_rdy), 32'd0);
                chk($sformatf("d%0d_rst_rsp_valid", d), 32'(a_rv), 32'd0);
                m_ptr[d]  = 0;
                m_pv[d]   = 1'b0;
                m_cyc[d]  = 0;
                m_init[d] = (d == 1);
                m_data[d] = 32'd0;
                m_dk[d]   = 1'b1;
                if (d == 0) begin
                    for (int a = 0; a < D; a++) begin
                        m_mem[0][a] = 32'd0;
                        m_kn[0][a]  = 4'hF;
                    end
                end
            end else begin
                e_rdy = 3'b000;
                found = 1'b0;
                g     = 0;
                if (m_init[d]) begin
                    for (int i = 0; i < N; i++) begin
                        j = (m_ptr[d] + i) % N;
                        if (!found && v[j]) begin
                            found = 1'b1;
                            g     = j;
                        end
                    end
                end
                if (found) e_rdy[g] = 1'b1;
                chk($sformatf("d%0d_ready", d), 32'(a_rdy), 32'(e_rdy));
                chk($sformatf("d%0d_rsp_valid", d), 32'(a_rv), m_pv[d] ? (32'd1 << m_pi[d]) : 32'd0);
                chk($sformatf("d%0d_init_done", d), 32'(a_id), 32'(m_init[d]));
                if (m_dk[d]) chk($sformatf("d%0d_rsp_data", d), a_dat, m_data[d]);
                // advance model to the next cycle
                m_pv[d] = 1'b0;
                if (found) begin
                    m_ptr[d] = (g + 1) % N;
                    ad = int'(addr[g*4 +: 4]);
                    if (wr[g]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[g*4 + b]) begin
                                m_mem[d][ad][b*8 +: 8] = wdat[g*32 + b*8 +: 8];
                                m_kn[d][ad][b] = 1'b1;
                            end
                        end
                    end else begin
                        m_pv[d]   = 1'b1;
                        m_pi[d]   = g;
                        m_data[d] = m_mem[d][ad];
                        m_dk[d]   = (m_kn[d][ad] == 4'hF);
                    end
                end
                if (!m_init[d]) begin
                    m_cyc[d]++;
                    if (m_cyc[d] >= D) m_init[d] = 1'b1;
                end
            end
            if (tv_on) begin
                chk($sformatf("tv%0d_d%0d_ready", tv_idx, d), 32'(a_rdy), 32'(tv[tv_idx].e_rdy));
                chk($sformatf("tv%0d_d%0d_rsp_valid", tv_idx, d), 32'(a_rv), 32'(tv[tv_idx].e_rv));
                if (tv[tv_idx].c_dat)
                    chk($sformatf("tv%0d_d%0d_rsp_data", tv_idx, d), a_dat, tv[tv_idx].e_dat);
            end
        end
        last_rdy = rdy0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = {3{a}};
        wdat = {3{d}};
        be   = {3{b}};
    endtask

    int          cnt;
    logic [31:0] rnd;

    initial begin
        //             v       wr      a      d             be     e_rdy   e_rv    e_dat         c
        tv[0]  = '{3'b111, 3'b000, 4'd0, 32'h0,        4'hF, 3'b001, 3'b000, 32'h0,        1'b0};
        tv[1]  = '{3'b111, 3'b000, 4'd0, 32'h0,        4'hF, 3'b010, 3'b001, 32'h0,        1'b0};
        tv[2]  = '{3'b111, 3'b000, 4'd0, 32'h0,        4'hF, 3'b100, 3'b010, 32'h0,        1'b0};
        tv[3]  = '{3'b111, 3'b000, 4'd0, 32'h0,        4'hF, 3'b001, 3'b100, 32'h0,        1'b0};
        tv[4]  = '{3'b111, 3'b000, 4'd0, 32'h0,        4'hF, 3'b010, 3'b001, 32'h0,        1'b0};
        tv[5]  = '{3'b111, 3'b000, 4'd0, 32'h0,        4'hF, 3'b100, 3'b010, 32'h0,        1'b0};
        tv[6]  = '{3'b001, 3'b001, 4'd5, 32'hAABBCCDD, 4'hF, 3'b001, 3'b100, 32'h0,        1'b0};
        tv[7]  = '{3'b001, 3'b001, 4'd5, 32'h11223344, 4'h5, 3'b001, 3'b000, 32'h0,        1'b0};
        tv[8]  = '{3'b001, 3'b000, 4'd5, 32'h0,        4'hF, 3'b001, 3'b000, 32'h0,        1'b0};
        tv[9]  = '{3'b000, 3'b000, 4'd0, 32'h0,        4'h0, 3'b000, 3'b001, 32'hAA22CC44, 1'b1};
        tv[10] = '{3'b010, 3'b010, 4'd3, 32'hDEADBEEF, 4'hF, 3'b010, 3'b000, 32'hAA22CC44, 1'b1};
        tv[11] = '{3'b010, 3'b000, 4'd3, 32'h0,        4'hF, 3'b010, 3'b000, 32'hAA22CC44, 1'b1};
        tv[12] = '{3'b000, 3'b000, 4'd0, 32'h0,        4'h0, 3'b000, 3'b010, 32'hDEADBEEF, 1'b1};
        tv[13] = '{3'b100, 3'b100, 4'd7, 32'h0BADF00D, 4'hF, 3'b100, 3'b000, 32'hDEADBEEF, 1'b1};
        tv[14] = '{3'b000, 3'b000, 4'd0, 32'h0,        4'h0, 3'b000, 3'b000, 32'hDEADBEEF, 1'b1};
        tv[15] = '{3'b100, 3'b000, 4'd7, 32'h0,        4'hF, 3'b100, 3'b000, 32'hDEADBEEF, 1'b1};
        tv[16] = '{3'b000, 3'b000, 4'd0, 32'h0,        4'h0, 3'b000, 3'b100, 32'h0BADF00D, 1'b1};
        tv[17] = '{3'b000, 3'b000, 4'd0, 32'h0,        4'h0, 3'b000, 3'b000, 32'h0BADF00D, 1'b1};

        rst = 1'b1;
        v   = 3'b000;
        wr  = 3'b000;
        set_all(4'd0, 32'd0, 4'hF);
        repeat (3) tick();
        rst = 1'b0;

        // Clear sweep: requester 0 reads every address, starting before init completes.
        cnt = 0;
        v   = 3'b001;
        repeat (36) begin
            tick();
            if (last_rdy[0] && cnt < D) begin
                cnt++;
                if (cnt == D) v = 3'b000;
                else          addr = {3{4'(cnt)}};
            end
        end

        // Fill every word so the CLEAR=0 instance has defined contents.
        cnt = 0;
        v   = 3'b001;
        wr  = 3'b001;
        rnd = $urandom;
        set_all(4'd0, rnd, 4'hF);
        repeat (20) begin
            tick();
            if (last_rdy[0] && cnt < D) begin
                cnt++;
                if (cnt == D) v = 3'b000;
                else begin
                    rnd = $urandom;
                    set_all(4'(cnt), rnd, 4'hF);
                end
            end
        end

        // Reset in the cycle after a read grant, then wait out the sweep.
        v  = 3'b001;
        wr = 3'b000;
        set_all(4'd2, 32'd0, 4'hF);
        tick();
        v   = 3'b000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (D) tick();

        // Directed vectors: round-robin order, byte enables, RAW, sparse requester 2.
        for (int i = 0; i < 18; i++) begin
            v  = tv[i].v;
            wr = tv[i].wr;
            set_all(tv[i].a, tv[i].d, tv[i].be);
            tv_idx = i;
            tv_on  = 1'b1;
            tick();
        end
        tv_on = 1'b0;
        v     = 3'b000;

        // Random traffic with one reset in the middle.
        for (int it = 0; it < 400; it++) begin
            rst = (it == 200);
            for (int k = 0; k < N; k++) begin
                if (!v[k] || last_rdy[k]) begin
                    v[k]              = 1'($urandom_range(0, 1));
                    wr[k]             = 1'($urandom_range(0, 1));
                    addr[k*4 +: 4]    = 4'($urandom_range(0, 15));
                    wdat[k*32 +: 32]  = $urandom;
                    be[k*4 +: 4]      = 4'($urandom_range(0, 15));
                end
            end
            tick();
        end
        rst = 1'b0;
        v   = 3'b000;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
